// File: rtl/spike_aer_encoder.sv
// Address-event encoder: latches one-cycle spike pulses per neuron, arbitrates them
// round-robin into a small FIFO of {timestamp, address} events, and counts lost spikes.
module spike_aer_encoder #(
    parameter int N_NEURONS  = 8,
    parameter int ADDR_W     = 3,
    parameter int TS_W       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_NEURONS-1:0] spike_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [ADDR_W-1:0]    evt_addr_o,
    output logic [TS_W-1:0]      evt_ts_o,
    output logic [7:0]           drop_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int POP_W = ADDR_W + 1;
    localparam int SUM_W = ((POP_W > 8) ? POP_W : 8) + 1;

    logic [TS_W-1:0]      r_ts;
    logic [N_NEURONS-1:0] r_pending;
    logic [TS_W-1:0]      r_ts_lat [N_NEURONS];
    logic [ADDR_W-1:0]    r_rr_ptr;
    logic [7:0]           r_drop_cnt;

    logic [ADDR_W-1:0]    r_fifo_addr [FIFO_DEPTH];
    logic [TS_W-1:0]      r_fifo_ts   [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_fifo_full;
    logic                 w_grant;
    logic                 w_gnt_found;
    logic [ADDR_W-1:0]    w_gnt_idx;
    logic [ADDR_W-1:0]    w_scan_idx;
    logic [N_NEURONS-1:0] w_gnt_vec;
    logic [N_NEURONS-1:0] w_drop;
    logic [N_NEURONS-1:0] w_lat_en;
    logic [POP_W-1:0]     w_drop_num;
    logic [SUM_W-1:0]     w_drop_sum;
    logic [7:0]           w_drop_next;
    logic                 w_push;
    logic                 w_pop;

    // Occupancy is judged before any same-cycle pop, so a full FIFO never passes through.
    assign w_fifo_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_grant     = (|r_pending) && !w_fifo_full;

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            w_scan_idx = r_rr_ptr + ADDR_W'(k);
            if (!w_gnt_found && r_pending[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            assign w_gnt_vec[gi] = w_grant && (w_gnt_idx == ADDR_W'(gi));
            // A spike on a granted neuron re-arms it with a fresh stamp instead of dropping.
            assign w_drop[gi]    = spike_i[gi] && r_pending[gi] && !w_gnt_vec[gi];
            assign w_lat_en[gi]  = spike_i[gi] && (!r_pending[gi] || w_gnt_vec[gi]);
        end
    endgenerate

    always_comb begin
        w_drop_num = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            w_drop_num = w_drop_num + POP_W'(w_drop[k]);
        end
    end

    assign w_drop_sum  = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_num);
    assign w_drop_next = (w_drop_sum > SUM_W'(255)) ? 8'hFF : w_drop_sum[7:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ts       <= '0;
            r_pending  <= '0;
            r_rr_ptr   <= '0;
            r_drop_cnt <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                r_ts_lat[k] <= '0;
            end
        end else begin
            r_ts       <= r_ts + TS_W'(1);
            r_pending  <= spike_i | (r_pending & ~w_gnt_vec);
            r_drop_cnt <= w_drop_next;
            for (int k = 0; k < N_NEURONS; k++) begin
                if (w_lat_en[k]) begin
                    r_ts_lat[k] <= r_ts;
                end
            end
            if (w_grant) begin
                r_rr_ptr <= w_gnt_idx + ADDR_W'(1);
            end
        end
    end

    assign evt_valid_o = (r_count != '0);
    assign w_push      = w_grant;
    assign w_pop       = evt_valid_o && evt_ready_i;

    // Storage is cleared on reset so the head reads 0 rather than stale data afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_fifo_addr[k] <= '0;
                r_fifo_ts[k]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= w_gnt_idx;
                r_fifo_ts[r_wr_ptr]   <= r_ts_lat[w_gnt_idx];
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign evt_addr_o = r_fifo_addr[r_rd_ptr];
    assign evt_ts_o   = r_fifo_ts[r_rd_ptr];
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: reset, latency, round-robin order,
// backpressure with drops, fairness, timestamp wrap, mid-run reset and drop saturation.
module tb_spike_aer_encoder;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] spike_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [2:0] evt_addr_o;
    logic [7:0] evt_ts_o;
    logic [7:0] drop_cnt_o;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] ts_model = 8'd0;
    logic [7:0] stamp;
    logic [7:0] stamp2;

    spike_aer_encoder #(
        .N_NEURONS (8),
        .ADDR_W    (3),
        .TS_W      (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .spike_i    (spike_i),
        .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i),
        .evt_addr_o (evt_addr_o),
        .evt_ts_o   (evt_ts_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    // One rising edge; ts_model tracks what the free-running timestamp becomes.
    task automatic tick();
        @(posedge clk);
        ts_model = rst_i ? 8'd0 : ts_model + 8'd1;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic [2:0] a, input logic [7:0] t);
        check({tag, ".valid"}, 32'(evt_valid_o), 32'd1);
        check({tag, ".addr"}, 32'(evt_addr_o), 32'(a));
        check({tag, ".ts"}, 32'(evt_ts_o), 32'(t));
        $display("evt %s: addr=%0d ts=%0d drop=%0d", tag, evt_addr_o, evt_ts_o, drop_cnt_o);
    endtask

    task automatic wait_ts(input logic [7:0] v);
        for (int g = 0; g < 300 && ts_model != v; g++) tick();
        check("wait_ts", 32'(ts_model), 32'(v));
    endtask

    initial begin
        // 1. Reset with all spikes asserted
        rst_i = 1'b1; spike_i = 8'hFF; evt_ready_i = 1'b1;
        tick(); tick();
        check("rst.valid", 32'(evt_valid_o), 32'd0);
        check("rst.drop", 32'(drop_cnt_o), 32'd0);
        check("rst.addr", 32'(evt_addr_o), 32'd0);
        check("rst.ts", 32'(evt_ts_o), 32'd0);
        rst_i = 1'b0; spike_i = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.idle", 32'(evt_valid_o), 32'd0);
        end

        // 2. Single spike on neuron 5 at ts 10
        wait_ts(8'd10);
        spike_i = 8'h20; tick(); spike_i = 8'h00;
        check("single.lat1", 32'(evt_valid_o), 32'd0);
        tick();
        check_evt("single", 3'd5, 8'd10);
        tick();
        check("single.popped", 32'(evt_valid_o), 32'd0);

        // Neuron 7 alone moves the round-robin pointer back to 0
        stamp = ts_model;
        spike_i = 8'h80; tick(); spike_i = 8'h00;
        tick();
        check_evt("prep7", 3'd7, stamp);
        tick();
        check("prep7.popped", 32'(evt_valid_o), 32'd0);

        // 3. Simultaneous spikes on 0 and 7
        stamp = ts_model;
        spike_i = 8'h81; tick(); spike_i = 8'h00;
        tick();
        check_evt("simul0", 3'd0, stamp);
        tick();
        check_evt("simul7", 3'd7, stamp);
        tick();
        check("simul.empty", 32'(evt_valid_o), 32'd0);

        // 4. Backpressure: FIFO fills with 0..3, 4..7 stay pending, then a drop on 6
        evt_ready_i = 1'b0;
        stamp = ts_model;
        spike_i = 8'hFF; tick(); spike_i = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        check_evt("bp.full", 3'd0, stamp);
        spike_i = 8'h40; tick(); spike_i = 8'h00;
        check("bp.drop", 32'(drop_cnt_o), 32'd1);
        check_evt("bp.held", 3'd0, stamp);
        evt_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_evt("bp.drain", 3'(i), stamp);
            tick();
        end
        check("bp.empty", 32'(evt_valid_o), 32'd0);
        check("bp.drop_keep", 32'(drop_cnt_o), 32'd1);

        // 5. Fairness: neurons 0 and 1 spike every cycle for six edges
        stamp = ts_model;
        spike_i = 8'h03; tick();
        check("fair.e1.drop", 32'(drop_cnt_o), 32'd1);
        check("fair.e1.valid", 32'(evt_valid_o), 32'd0);
        for (int n = 2; n <= 8; n++) begin
            if (n == 7) spike_i = 8'h00;
            tick();
            check_evt("fair", 3'(n % 2), (n == 2) ? stamp : stamp + 8'(n - 3));
            check("fair.drop", 32'(drop_cnt_o), (n <= 6) ? 32'(n) : 32'd6);
        end
        tick();
        check("fair.empty", 32'(evt_valid_o), 32'd0);

        // 6a. Timestamp wrap 255 -> 0
        wait_ts(8'd255);
        spike_i = 8'h01; tick();
        spike_i = 8'h02; tick(); spike_i = 8'h00;
        check_evt("wrap255", 3'd0, 8'd255);
        tick();
        check_evt("wrap0", 3'd1, 8'd0);
        tick();
        check("wrap.empty", 32'(evt_valid_o), 32'd0);
        check("wrap.drop", 32'(drop_cnt_o), 32'd6);

        // 6b. Reset while the FIFO is full and neurons are pending
        evt_ready_i = 1'b0;
        stamp2 = ts_model;
        spike_i = 8'hFF; tick(); spike_i = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        check_evt("midrst.full", 3'd2, stamp2);
        rst_i = 1'b1; tick();
        check("midrst.valid", 32'(evt_valid_o), 32'd0);
        check("midrst.drop", 32'(drop_cnt_o), 32'd0);
        check("midrst.addr", 32'(evt_addr_o), 32'd0);
        check("midrst.ts", 32'(evt_ts_o), 32'd0);
        rst_i = 1'b0; evt_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst.idle", 32'(evt_valid_o), 32'd0);
        end

        // 7. Eight neurons spiking continuously: 7 drops per edge, clamped at 255
        spike_i = 8'hFF;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1)  check("sat.e1", 32'(drop_cnt_o), 32'd0);
            if (n == 2)  check("sat.e2", 32'(drop_cnt_o), 32'd7);
            if (n == 37) check("sat.e37", 32'(drop_cnt_o), 32'd252);
            if (n == 38) check("sat.e38", 32'(drop_cnt_o), 32'd255);
            if (n == 40) check("sat.e40", 32'(drop_cnt_o), 32'd255);
        end
        spike_i = 8'h00;
        tick();
        check("sat.hold", 32'(drop_cnt_o), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
